// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 Gaussian blur datapath.
//   PIX_W / SUM_W : pixel and kernel-sum widths
//   W00..W22      : 1-2-1 / 2-4-2 / 1-2-1 kernel weights
//   SHIFT         : normalisation shift applied to the weighted sum
//   state_t       : window scheduler FSM states
//   k_row / k_col : row/column offset of tap k inside a row-major 3x3 window
package conv_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned KW    = 4;

    localparam int unsigned W00 = 1;
    localparam int unsigned W01 = 2;
    localparam int unsigned W02 = 1;
    localparam int unsigned W10 = 2;
    localparam int unsigned W11 = 4;
    localparam int unsigned W12 = 2;
    localparam int unsigned W20 = 1;
    localparam int unsigned W21 = 2;
    localparam int unsigned W22 = 1;

    localparam int unsigned SHIFT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CALC,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Row offset of tap k (k = 0..8, row-major)
    function automatic logic [1:0] k_row(input logic [KW-1:0] k);
        logic [1:0] r;
        if (k >= KW'(6))      r = 2'd2;
        else if (k >= KW'(3)) r = 2'd1;
        else                  r = 2'd0;
        return r;
    endfunction

    // Column offset of tap k (k = 0..8, row-major)
    function automatic logic [1:0] k_col(input logic [KW-1:0] k);
        logic [1:0] c;
        case (k)
            KW'(0), KW'(3), KW'(6): c = 2'd0;
            KW'(1), KW'(4), KW'(7): c = 2'd1;
            default:                c = 2'd2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gauss3x3_sum.sv
// Combinational 3x3 Gaussian kernel: weighted sum of nine pixels, >> SHIFT.
//   win : nine 8-bit pixels, slot k at win[8k +: 8], row-major (k = 3*row + col)
//   pix : blurred pixel, truncated (no rounding)
module gauss3x3_sum
    import conv_pkg::*;
(
    input  logic [9*PIX_W-1:0] win,
    output logic [PIX_W-1:0]   pix
);

    logic [SUM_W-1:0] sum;

    function automatic logic [SUM_W-1:0] tap(input logic [PIX_W-1:0] p,
                                             input int unsigned      w);
        return SUM_W'(p) * SUM_W'(w);
    endfunction

    // Max sum is 16*255 = 4080, so SUM_W bits never overflow
    always_comb begin
        sum = tap(win[0*PIX_W +: PIX_W], W00)
            + tap(win[1*PIX_W +: PIX_W], W01)
            + tap(win[2*PIX_W +: PIX_W], W02)
            + tap(win[3*PIX_W +: PIX_W], W10)
            + tap(win[4*PIX_W +: PIX_W], W11)
            + tap(win[5*PIX_W +: PIX_W], W12)
            + tap(win[6*PIX_W +: PIX_W], W20)
            + tap(win[7*PIX_W +: PIX_W], W21)
            + tap(win[8*PIX_W +: PIX_W], W22);
        pix = PIX_W'(sum >> SHIFT);
    end

endmodule

// File: rtl/conv_window_sched.sv
// Window sequencer for the 3x3 Gaussian blur: walks every valid 3x3 window of
// an IMG_W x IMG_H image in a 1-cycle-latency pixel memory, fetches the nine
// taps, and emits one blurred pixel per window over a valid/ready port.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : begin a full-image pass (only honoured in IDLE)
//   busy, done    : pass in progress / one-cycle end-of-pass pulse
//   rd_en/rd_addr : pixel read request, row-major address
//   rd_data       : pixel returned the cycle after rd_en
//   res_valid/res_ready/res_pixel/res_idx : result handshake and payload
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 4,
    parameter int unsigned IMG_H = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned OW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_pixel,
    output logic [OW-1:0] res_idx
);

    localparam int unsigned CW = (IMG_W > IMG_H) ? $clog2(IMG_W) : $clog2(IMG_H);
    localparam logic [CW-1:0] WJ_LAST = CW'(IMG_W - 3);
    localparam logic [CW-1:0] WI_LAST = CW'(IMG_H - 3);
    localparam logic [KW-1:0] K_LAST  = KW'(8);

    state_t              state;
    state_t              state_nxt;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_nxt;
    logic [CW-1:0]       wi;
    logic [CW-1:0]       wi_nxt;
    logic [CW-1:0]       wj;
    logic [CW-1:0]       wj_nxt;

    logic                rd_en_nxt;
    logic [AW-1:0]       rd_addr_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                res_valid_nxt;

    logic [PIX_W-1:0]    win_q [8];
    logic [9*PIX_W-1:0]  win_bus;
    logic [PIX_W-1:0]    blur;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state plus window position and tap counter
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        wi_nxt    = wi;
        wj_nxt    = wj;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    k_nxt     = '0;
                    wi_nxt    = '0;
                    wj_nxt    = '0;
                end
            end
            ST_FETCH: begin
                if (k == K_LAST) state_nxt = ST_CALC;
                else             k_nxt     = k + KW'(1);
            end
            ST_CALC: begin
                state_nxt = ST_EMIT;
                k_nxt     = '0;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    if (wi == WI_LAST && wj == WJ_LAST) begin
                        state_nxt = ST_DONE;
                        wi_nxt    = '0;
                        wj_nxt    = '0;
                    end else begin
                        state_nxt = ST_FETCH;
                        if (wj < WJ_LAST) begin
                            wj_nxt = wj + CW'(1);
                        end else begin
                            wj_nxt = '0;
                            wi_nxt = wi + CW'(1);
                        end
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k  <= '0;
            wi <= '0;
            wj <= '0;
        end else begin
            k  <= k_nxt;
            wi <= wi_nxt;
            wj <= wj_nxt;
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = '0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        res_valid_nxt = 1'b0;
        case (state_nxt)
            ST_FETCH: begin
                rd_en_nxt   = 1'b1;
                busy_nxt    = 1'b1;
                rd_addr_nxt = AW'((32'(wi_nxt) + 32'(k_row(k_nxt))) * 32'(IMG_W)
                                  + 32'(wj_nxt) + 32'(k_col(k_nxt)));
            end
            ST_CALC: busy_nxt = 1'b1;
            ST_EMIT: begin
                busy_nxt      = 1'b1;
                res_valid_nxt = 1'b1;
            end
            ST_DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers; result payload loads in CALC and holds through EMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_pixel <= '0;
            res_idx   <= '0;
        end else begin
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            res_valid <= res_valid_nxt;
            if (state == ST_CALC) begin
                res_pixel <= blur;
                res_idx   <= OW'(32'(wi) * 32'(IMG_W - 2) + 32'(wj));
            end
        end
    end

    // Tap k-1 returns while tap k is being requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) win_q[i] <= '0;
        end else if (state == ST_FETCH && k != '0) begin
            win_q[3'(k - KW'(1))] <= rd_data;
        end
    end

    // The ninth tap is consumed straight from the memory in CALC
    always_comb begin
        win_bus = '0;
        for (int i = 0; i < 8; i++) win_bus[i*PIX_W +: PIX_W] = win_q[i];
        win_bus[8*PIX_W +: PIX_W] = rd_data;
    end

    gauss3x3_sum u_sum (
        .win (win_bus),
        .pix (blur)
    );

endmodule
